// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and execute-side update bundle for the direct-mapped BTB.
// The predictor is the slave; the pipeline (or a testbench) drives it as master.
interface branch_predictor_btb_if;
  logic [31:0] PCF;
  logic        BtbHitF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateEnE;
  logic [31:0] PCE;
  logic        BrTakenE;
  logic [31:0] BrTargetE;
  logic        BranchPredictedTakenE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  modport slave (
    input  PCF, UpdateEnE, PCE, BrTakenE, BrTargetE, BranchPredictedTakenE,
    output BtbHitF, PredTakenF, PredTargetF, BranchCnt, MispredCnt
  );

  modport master (
    output PCF, UpdateEnE, PCE, BrTakenE, BrTargetE, BranchPredictedTakenE,
    input  BtbHitF, PredTakenF, PredTargetF, BranchCnt, MispredCnt
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Combinational IF-stage lookup, EX-stage update, plus run-long branch statistics.
module branch_predictor_btb #(
  parameter int          IDX_W     = 6,
  parameter logic [1:0]  ALLOC_CNT = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_btb_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt_e;

  logic [ENTRIES-1:0] r_valid;
  cnt_e               r_cnt    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [31:0]        r_branch_cnt;
  logic [31:0]        r_mispred_cnt;

  // Fetch-side lookup
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;

  assign w_f_idx = bus.PCF[IDX_W+1:2];
  assign w_f_tag = bus.PCF[31:IDX_W+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  assign bus.BtbHitF     = w_f_hit;
  assign bus.PredTakenF  = w_f_hit && (r_cnt[w_f_idx] >= WEAK_T);
  assign bus.PredTargetF = w_f_hit ? r_target[w_f_idx] : 32'b0;

  // Execute-side update, evaluated against the table as it stands this cycle
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_alloc;
  logic             w_tgt_we;
  cnt_e             w_cnt_next;

  assign w_u_idx  = bus.PCE[IDX_W+1:2];
  assign w_u_tag  = bus.PCE[31:IDX_W+2];
  assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_alloc  = bus.UpdateEnE && !w_u_hit && bus.BrTakenE;
  assign w_tgt_we = bus.UpdateEnE && bus.BrTakenE;

  // Byte-offset bits never select an entry.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{bus.PCF[1:0], bus.PCE[1:0]};

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_cnt_next = r_cnt[w_u_idx];
    if (bus.BrTakenE) begin
      if (r_cnt[w_u_idx] != STRONG_T) w_cnt_next = cnt_e'(r_cnt[w_u_idx] + 2'd1);
    end else begin
      if (r_cnt[w_u_idx] != STRONG_NT) w_cnt_next = cnt_e'(r_cnt[w_u_idx] - 2'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_cnt         <= '{default: WEAK_NT};
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (bus.UpdateEnE) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (bus.BrTakenE != bus.BranchPredictedTakenE && r_mispred_cnt != '1)
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      if (w_u_hit) begin
        r_cnt[w_u_idx] <= w_cnt_next;
      end else if (bus.BrTakenE) begin
        r_valid[w_u_idx] <= 1'b1;
        r_cnt[w_u_idx]   <= cnt_e'(ALLOC_CNT);
      end
    end
  end

  // NOTE: tag/target storage has no reset; a cleared valid bit makes its contents irrelevant.
  always_ff @(posedge clk) begin
    if (w_tgt_we) r_target[w_u_idx] <= bus.BrTargetE;
    if (w_alloc)  r_tag[w_u_idx]    <= w_u_tag;
  end

  assign bus.BranchCnt  = r_branch_cnt;
  assign bus.MispredCnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: hand-computed lookups and statistics after
// allocation, counter walk, aliasing, same-cycle update, back-to-back updates and reset.
module tb_branch_predictor_btb;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_branch;
  int   exp_mispred;

  branch_predictor_btb_if bus ();

  branch_predictor_btb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic pred);
    @(negedge clk);
    bus.UpdateEnE             = 1'b1;
    bus.PCE                   = pc;
    bus.BrTakenE              = taken;
    bus.BrTargetE             = tgt;
    bus.BranchPredictedTakenE = pred;
    @(posedge clk);
    #1;
    bus.UpdateEnE = 1'b0;
    exp_branch++;
    if (taken != pred) exp_mispred++;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    bus.PCF = pc;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_pc(32'h100);
    checks++;
    if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== 34'b0) begin
      failures++;
      $display("FAIL reset_held_lookup got=%h exp=0", {bus.BtbHitF, bus.PredTakenF, bus.PredTargetF});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      set_pc(32'(i) * 32'd4);
      checks++;
      if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== 34'b0) begin
        failures++;
        $display("FAIL reset_sweep pc=%h got=%h exp=0", bus.PCF,
                 {bus.BtbHitF, bus.PredTakenF, bus.PredTargetF});
      end
    end
    checks++;
    if (bus.BranchCnt !== 32'd0 || bus.MispredCnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.BranchCnt, bus.MispredCnt);
    end
  endtask

  task automatic test_alloc;
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    set_pc(32'h100);
    checks++;
    if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== {2'b11, 32'h200}) begin
      failures++;
      $display("FAIL alloc_lookup got=%b/%b/%h exp=1/1/00000200",
               bus.BtbHitF, bus.PredTakenF, bus.PredTargetF);
    end
    checks++;
    if (bus.BranchCnt !== 32'd1 || bus.MispredCnt !== 32'd1) begin
      failures++;
      $display("FAIL alloc_counts got=%0d/%0d exp=1/1", bus.BranchCnt, bus.MispredCnt);
    end
  endtask

  task automatic test_counter_decay;
    logic exp_taken [3] = '{1'b0, 1'b0, 1'b0};
    logic pred      [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_update(32'h100, 1'b0, 32'hDEAD_0000, pred[i]);
      set_pc(32'h100);
      checks++;
      if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== {1'b1, exp_taken[i], 32'h200}) begin
        failures++;
        $display("FAIL decay_step%0d got=%b/%b/%h exp=1/%b/00000200", i,
                 bus.BtbHitF, bus.PredTakenF, bus.PredTargetF, exp_taken[i]);
      end
    end
    checks++;
    if (bus.BranchCnt !== 32'(exp_branch) || bus.MispredCnt !== 32'(exp_mispred)) begin
      failures++;
      $display("FAIL decay_counts got=%0d/%0d exp=%0d/%0d",
               bus.BranchCnt, bus.MispredCnt, exp_branch, exp_mispred);
    end
  endtask

  // From 00: T,T,T,T climbs to 11 and saturates; then NT,NT walks 11->10->01.
  task automatic test_saturate;
    logic taken     [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic pred      [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_taken [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_update(32'h100, taken[i], 32'h240, pred[i]);
      set_pc(32'h100);
      checks++;
      if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== {1'b1, exp_taken[i], 32'h240}) begin
        failures++;
        $display("FAIL sat_step%0d got=%b/%b/%h exp=1/%b/00000240", i,
                 bus.BtbHitF, bus.PredTakenF, bus.PredTargetF, exp_taken[i]);
      end
    end
    checks++;
    if (bus.BranchCnt !== 32'(exp_branch) || bus.MispredCnt !== 32'(exp_mispred)) begin
      failures++;
      $display("FAIL sat_counts got=%0d/%0d exp=%0d/%0d",
               bus.BranchCnt, bus.MispredCnt, exp_branch, exp_mispred);
    end
  endtask

  task automatic test_alias;
    set_pc(32'h200);
    checks++;
    if (bus.BtbHitF !== 1'b0) begin
      failures++;
      $display("FAIL alias_pre_miss got=%b exp=0", bus.BtbHitF);
    end
    do_update(32'h200, 1'b1, 32'h300, 1'b0);
    set_pc(32'h202);
    checks++;
    if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== {2'b11, 32'h300}) begin
      failures++;
      $display("FAIL alias_new_hit got=%b/%b/%h exp=1/1/00000300",
               bus.BtbHitF, bus.PredTakenF, bus.PredTargetF);
    end
    set_pc(32'h100);
    checks++;
    if ({bus.BtbHitF, bus.PredTargetF} !== 33'b0) begin
      failures++;
      $display("FAIL alias_old_miss got=%b/%h exp=0/00000000", bus.BtbHitF, bus.PredTargetF);
    end
    do_update(32'h500, 1'b0, 32'h900, 1'b0);
    set_pc(32'h200);
    checks++;
    if ({bus.BtbHitF, bus.PredTargetF} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL miss_nt_nochange got=%b/%h exp=1/00000300", bus.BtbHitF, bus.PredTargetF);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    bus.PCF                   = 32'h400;
    bus.UpdateEnE             = 1'b1;
    bus.PCE                   = 32'h400;
    bus.BrTakenE              = 1'b1;
    bus.BrTargetE             = 32'h480;
    bus.BranchPredictedTakenE = 1'b1;
    #1;
    checks++;
    if (bus.BtbHitF !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_pre got=%b exp=0", bus.BtbHitF);
    end
    @(posedge clk);
    #1;
    bus.UpdateEnE = 1'b0;
    exp_branch++;
    checks++;
    if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== {2'b11, 32'h480}) begin
      failures++;
      $display("FAIL same_cycle_post got=%b/%b/%h exp=1/1/00000480",
               bus.BtbHitF, bus.PredTakenF, bus.PredTargetF);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.UpdateEnE             = 1'b1;
    bus.PCE                   = 32'h104;
    bus.BrTakenE              = 1'b1;
    bus.BrTargetE             = 32'h1104;
    bus.BranchPredictedTakenE = 1'b1;
    @(posedge clk);
    #1;
    bus.PCE                   = 32'h108;
    bus.BrTargetE             = 32'h1108;
    bus.BranchPredictedTakenE = 1'b0;
    @(posedge clk);
    #1;
    bus.UpdateEnE = 1'b0;
    exp_branch  += 2;
    exp_mispred += 1;
    set_pc(32'h104);
    checks++;
    if ({bus.BtbHitF, bus.PredTargetF} !== {1'b1, 32'h1104}) begin
      failures++;
      $display("FAIL b2b_first got=%b/%h exp=1/00001104", bus.BtbHitF, bus.PredTargetF);
    end
    set_pc(32'h108);
    checks++;
    if ({bus.BtbHitF, bus.PredTargetF} !== {1'b1, 32'h1108}) begin
      failures++;
      $display("FAIL b2b_second got=%b/%h exp=1/00001108", bus.BtbHitF, bus.PredTargetF);
    end
    checks++;
    if (bus.BranchCnt !== 32'(exp_branch) || bus.MispredCnt !== 32'(exp_mispred)) begin
      failures++;
      $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d",
               bus.BranchCnt, bus.MispredCnt, exp_branch, exp_mispred);
    end
  endtask

  task automatic test_reset_midcycle;
    @(negedge clk);
    bus.PCF                   = 32'h400;
    bus.UpdateEnE             = 1'b1;
    bus.PCE                   = 32'h600;
    bus.BrTakenE              = 1'b1;
    bus.BrTargetE             = 32'h700;
    bus.BranchPredictedTakenE = 1'b0;
    #1;
    checks++;
    if (bus.BtbHitF !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_hit got=%b exp=1", bus.BtbHitF);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.BtbHitF, bus.PredTakenF, bus.PredTargetF} !== 34'b0 || bus.BranchCnt !== 32'd0) begin
      failures++;
      $display("FAIL midrst_clear got=%b/%b/%h cnt=%0d exp=0/0/00000000 cnt=0",
               bus.BtbHitF, bus.PredTakenF, bus.PredTargetF, bus.BranchCnt);
    end
    @(posedge clk);
    #1;
    bus.UpdateEnE = 1'b0;
    rst_n = 1'b1;
    exp_branch  = 0;
    exp_mispred = 0;
    set_pc(32'h600);
    checks++;
    if (bus.BtbHitF !== 1'b0 || bus.BranchCnt !== 32'd0 || bus.MispredCnt !== 32'd0) begin
      failures++;
      $display("FAIL midrst_after got=%b cnt=%0d/%0d exp=0 cnt=0/0",
               bus.BtbHitF, bus.BranchCnt, bus.MispredCnt);
    end
  endtask

  initial begin
    checks                    = 0;
    failures                  = 0;
    exp_branch                = 0;
    exp_mispred               = 0;
    rst_n                     = 1'b0;
    bus.PCF                   = '0;
    bus.UpdateEnE             = 1'b0;
    bus.PCE                   = '0;
    bus.BrTakenE              = 1'b0;
    bus.BrTargetE             = '0;
    bus.BranchPredictedTakenE = 1'b0;

    test_reset();
    test_alloc();
    test_counter_decay();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_reset_midcycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
